// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad ports: button bit positions,
// four-score signature bytes, default shift length and turbo slot order.
package nes_joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int PAD_W           = 8;
    localparam int DEFAULT_SHIFT_W = 24;
    localparam int FS_FRAME_W      = 24;

    localparam logic [7:0] FS_SIG_PORT0 = 8'h08;
    localparam logic [7:0] FS_SIG_PORT1 = 8'h04;
    localparam logic [7:0] FS_SIG_NONE  = 8'h00;

    // Turbo enable bits are packed four per port in this order.
    typedef enum logic [1:0] {
        TB_PRI_A = 2'd0,
        TB_PRI_B = 2'd1,
        TB_SEC_A = 2'd2,
        TB_SEC_B = 2'd3
    } turbo_slot_e;

    function automatic logic [7:0] fs_signature(input int port);
        case (port)
            0:       return FS_SIG_PORT0;
            1:       return FS_SIG_PORT1;
            default: return FS_SIG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/nes_joypad_shift.sv
// One controller port: joy_clk falling-edge detector and the serial shift
// register whose LSB drives the CPU data line.
module nes_joypad_shift
    import nes_joypad_pkg::*;
#(
    parameter int   SHIFT_W  = DEFAULT_SHIFT_W,
    parameter logic FILL_BIT = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_i,
    input  logic               load_i,
    input  logic [SHIFT_W-1:0] load_val_i,
    input  logic               joy_clk_i,
    output logic               dout_o
);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               jclk_q, jclk_d;
    logic               fall;

    assign fall = jclk_q && !joy_clk_i;

    // A load while strobe is high swallows any coincident read edge.
    always_comb begin
        shift_d = shift_q;
        jclk_d  = jclk_q;
        if (ce_i) begin
            jclk_d = joy_clk_i;
            if (load_i) begin
                shift_d = load_val_i;
            end else if (fall) begin
                shift_d = {FILL_BIT, shift_q[SHIFT_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q <= '0;
            jclk_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            jclk_q  <= jclk_d;
        end
    end

    assign dout_o = shift_q[0];

endmodule

// File: rtl/nes_joypad_ports.sv
// NES $4016/$4017 controller ports with optional four-score framing.
// Optional turbo support is compiled in with `define JOYPAD_TURBO_EN.
module nes_joypad_ports
    import nes_joypad_pkg::*;
#(
    parameter int   NUM_PORTS = 2,
    parameter int   SHIFT_W   = DEFAULT_SHIFT_W,
    parameter logic FILL_BIT  = 1'b1
`ifdef JOYPAD_TURBO_EN
    ,
    parameter int   TURBO_DIV = 4
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   block_in,
    input  logic                   strobe,
    input  logic [NUM_PORTS-1:0]   joy_clk,
    input  logic [NUM_PORTS*8-1:0] pad_pri,
    input  logic [NUM_PORTS*8-1:0] pad_sec,
    input  logic                   fourscore,
`ifdef JOYPAD_TURBO_EN
    input  logic [NUM_PORTS*4-1:0] turbo,
`endif
    output logic [NUM_PORTS-1:0]   dout
);

    if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
        $error("NUM_PORTS must be in 1..4");
    end
    if (SHIFT_W < PAD_W) begin : g_bad_shift
        $error("SHIFT_W must be at least 8");
    end

`ifdef JOYPAD_TURBO_EN
    localparam int CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             phase_q, phase_d;

    // Phase flips once every TURBO_DIV strobe rising edges.
    always_comb begin
        strobe_d = strobe_q;
        tcnt_d   = tcnt_q;
        phase_d  = phase_q;
        if (ce) begin
            strobe_d = strobe;
            if (strobe && !strobe_q) begin
                if (tcnt_q == CNT_W'(TURBO_DIV - 1)) begin
                    tcnt_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            tcnt_q   <= '0;
            phase_q  <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            tcnt_q   <= tcnt_d;
            phase_q  <= phase_d;
        end
    end
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [7:0]         pri_mask, sec_mask;
        logic [7:0]         pri_bits, sec_bits;
        logic [SHIFT_W-1:0] load_val;

`ifdef JOYPAD_TURBO_EN
        always_comb begin
            pri_mask = '1;
            sec_mask = '1;
            pri_mask[BTN_A] = ~turbo[p*4 + int'(TB_PRI_A)] | phase_q;
            pri_mask[BTN_B] = ~turbo[p*4 + int'(TB_PRI_B)] | phase_q;
            sec_mask[BTN_A] = ~turbo[p*4 + int'(TB_SEC_A)] | phase_q;
            sec_mask[BTN_B] = ~turbo[p*4 + int'(TB_SEC_B)] | phase_q;
        end
`else
        assign pri_mask = '1;
        assign sec_mask = '1;
`endif

        // Blocking zeroes only the button bits; signature and fill survive.
        assign pri_bits = block_in ? 8'h00 : (pad_pri[p*8 +: 8] & pri_mask);
        assign sec_bits = block_in ? 8'h00 : (pad_sec[p*8 +: 8] & sec_mask);

        if (SHIFT_W >= FS_FRAME_W) begin : g_fs
            always_comb begin
                load_val      = {SHIFT_W{FILL_BIT}};
                load_val[7:0] = pri_bits;
                if (fourscore) begin
                    load_val[15:8]  = sec_bits;
                    load_val[23:16] = fs_signature(p);
                end
            end
        end else begin : g_std
            // Too short for a four-score frame: always the standard format.
            always_comb begin
                load_val      = {SHIFT_W{FILL_BIT}};
                load_val[7:0] = pri_bits;
            end
        end

        nes_joypad_shift #(
            .SHIFT_W  (SHIFT_W),
            .FILL_BIT (FILL_BIT)
        ) u_shift (
            .clk        (clk),
            .reset_n    (reset_n),
            .ce_i       (ce),
            .load_i     (strobe),
            .load_val_i (load_val),
            .joy_clk_i  (joy_clk[p]),
            .dout_o     (dout[p])
        );
    end

endmodule

// File: tb/tb_nes_joypad_ports.sv
// Randomized and directed bench for nes_joypad_ports against a queue-based
// reference model of what the CPU should read from each port.
module tb_nes_joypad_ports;

    localparam int   NP   = 2;
    localparam int   SW   = 24;
    localparam logic FILL = 1'b1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            ce = 1'b1;
    logic            block_in = 1'b0;
    logic            strobe = 1'b0;
    logic [NP-1:0]   joy_clk = '0;
    logic [NP*8-1:0] pad_pri = '0;
    logic [NP*8-1:0] pad_sec = '0;
    logic            fourscore = 1'b0;
    logic [NP-1:0]   dout;

    int checks = 0;
    int errors = 0;

    // Model: each port is the list of bits the CPU will still read, in order.
    bit mq [NP][$];
    bit mprev [NP];

    always #5 clk = ~clk;

    nes_joypad_ports #(
        .NUM_PORTS (NP),
        .SHIFT_W   (SW),
        .FILL_BIT  (FILL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .block_in  (block_in),
        .strobe    (strobe),
        .joy_clk   (joy_clk),
        .pad_pri   (pad_pri),
        .pad_sec   (pad_sec),
        .fourscore (fourscore),
`ifdef JOYPAD_TURBO_EN
        .turbo     ('0),
`endif
        .dout      (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_load(input int p);
        logic [7:0] sig;
        mq[p].delete();
        for (int i = 0; i < 8; i++) mq[p].push_back(block_in ? 1'b0 : pad_pri[p*8+i]);
        if (fourscore) begin
            sig = (p == 0) ? 8'h08 : (p == 1) ? 8'h04 : 8'h00;
            for (int i = 0; i < 8; i++) mq[p].push_back(block_in ? 1'b0 : pad_sec[p*8+i]);
            for (int i = 0; i < 8; i++) mq[p].push_back(sig[i]);
        end
    endtask

    task automatic model_step();
        bit fall;
        for (int p = 0; p < NP; p++) begin
            if (!reset_n) begin
                mq[p].delete();
                repeat (SW) mq[p].push_back(1'b0);
                mprev[p] = 1'b0;
            end else if (ce) begin
                fall = mprev[p] && !joy_clk[p];
                mprev[p] = joy_clk[p];
                if (strobe) model_load(p);
                else if (fall && mq[p].size() > 0) void'(mq[p].pop_front());
            end
        end
    endtask

    function automatic logic model_dout(input int p);
        return (mq[p].size() > 0) ? mq[p][0] : FILL;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("model_p%0d", p), 32'(dout[p]), 32'(model_dout(p)));
    endtask

    task automatic do_load();
        strobe = 1'b1;
        cycle();
        strobe = 1'b0;
    endtask

    task automatic read_edge(input int p);
        joy_clk[p] = 1'b1;
        cycle();
        joy_clk[p] = 1'b0;
        cycle();
    endtask

    initial begin
        logic [7:0] exp_std;

        reset_n = 1'b0;
        cycle();
        check("reset_p0", 32'(dout[0]), 32'd0);
        check("reset_p1", 32'(dout[1]), 32'd0);
        reset_n = 1'b1;
        cycle();

        // Standard read of 0x09.
        exp_std = 8'h09;
        pad_pri = 16'h0009;
        do_load();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("std_bit%0d", i), 32'(dout[0]), 32'(exp_std[i]));
            read_edge(0);
        end
        for (int i = 0; i < 3; i++) begin
            check("std_fill", 32'(dout[0]), 32'd1);
            read_edge(0);
        end

        // Four-score frame on port 0.
        fourscore = 1'b1;
        pad_pri = 16'h0001;
        pad_sec = 16'h0080;
        do_load();
        for (int i = 0; i < 24; i++) begin
            check($sformatf("fs_bit%0d", i), 32'(dout[0]), (i == 0 || i == 15 || i == 19) ? 32'd1 : 32'd0);
            read_edge(0);
        end
        check("fs_fill", 32'(dout[0]), 32'd1);
        read_edge(0);
        check("fs_fill2", 32'(dout[0]), 32'd1);
        fourscore = 1'b0;

        // Strobe held high: dout follows A, read clocks ignored.
        strobe = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pad_pri[0] = k[0];
            joy_clk[0] = k[1];
            cycle();
            check("strobe_track", 32'(dout[0]), 32'(k[0]));
        end
        strobe = 1'b0;
        joy_clk = '0;
        cycle();

        // Load and falling edge in the same cycle.
        pad_pri = 16'h0002;
        do_load();
        joy_clk[0] = 1'b1;
        cycle();
        pad_pri = 16'h0003;
        strobe = 1'b1;
        joy_clk[0] = 1'b0;
        cycle();
        strobe = 1'b0;
        check("sim_load_a", 32'(dout[0]), 32'd1);
        read_edge(0);
        check("sim_load_b", 32'(dout[0]), 32'd1);
        read_edge(0);
        check("sim_load_sel", 32'(dout[0]), 32'd0);

        // Blocked pad reads as zeros, then fill.
        block_in = 1'b1;
        pad_pri = 16'hFFFF;
        do_load();
        block_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("block_zero", 32'(dout[0]), 32'd0);
            read_edge(0);
        end
        check("block_fill", 32'(dout[0]), 32'd1);

        // Ports shift independently.
        pad_pri = 16'h0201;
        do_load();
        read_edge(1);
        check("indep_p0", 32'(dout[0]), 32'd1);
        check("indep_p1", 32'(dout[1]), 32'd1);

        // Reset in the middle of a read.
        pad_pri = 16'h0009;
        do_load();
        repeat (3) read_edge(0);
        reset_n = 1'b0;
        cycle();
        check("midrst_p0", 32'(dout[0]), 32'd0);
        reset_n = 1'b1;
        cycle();
        check("midrst_hold", 32'(dout[0]), 32'd0);
        do_load();
        check("midrst_a", 32'(dout[0]), 32'd1);
        read_edge(0);
        check("midrst_b", 32'(dout[0]), 32'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int n = 0; n < 1500; n++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            ce        = ($urandom_range(0, 3) != 0);
            strobe    = ($urandom_range(0, 15) == 0);
            joy_clk   = NP'($urandom);
            block_in  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) fourscore = ~fourscore;
            pad_pri   = 16'($urandom);
            pad_sec   = 16'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
